// File: rtl/minivan_pkg.sv
// minivan_pkg: shared fade FSM encoding, default widths and the per-channel step helper
package minivan_pkg;
  localparam int DIV_W_DEF = 16;
  localparam int STEP_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, RAMP, DONE} fade_state_t;
  function automatic logic [7:0] step_toward(input logic [7:0] duty, input logic [7:0] goal, input logic [8:0] step);
    logic signed [8:0] diff;
    logic [8:0] mag;
    diff = $signed({1'b0, goal}) - $signed({1'b0, duty});
    mag = diff[8] ? 9'(-diff) : 9'(diff);
    return (mag <= step) ? goal : diff[8] ? duty - step[7:0] : duty + step[7:0];
  endfunction
endpackage

// File: rtl/led_fade_prescaler.sv
// led_fade_prescaler: tick every period+1 cycles while clr is low, counter held at 0 while clr is high
module led_fade_prescaler
  import minivan_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             clr,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = !clr && (cnt_q >= period);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_fade_ctrl.sv
// led_fade_ctrl: RGB duty fader (IDLE/RAMP/DONE), breathing mode enabled by LED_FADE_BREATHE_EN
module led_fade_ctrl
  import minivan_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              ena,
  input  logic [7:0]        target_r,
  input  logic [7:0]        target_g,
  input  logic [7:0]        target_b,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [STEP_W-1:0] step_size,
  input  logic              breathe,
  output logic [7:0]        duty_r,
  output logic [7:0]        duty_g,
  output logic [7:0]        duty_b,
  output logic              busy,
  output logic              done
);
  fade_state_t state_q, state_d;
  logic [7:0] duty_r_q, duty_g_q, duty_b_q, duty_r_d, duty_g_d, duty_b_d;
  logic [7:0] goal_r, goal_g, goal_b;
  logic [8:0] step;
  logic phase_q, brth, tick, at_goal, upd, clr;
`ifdef LED_FADE_BREATHE_EN
  logic phase_d;
  assign brth = breathe;
  assign phase_d = (state_d == IDLE) ? 1'b0 : (state_q == DONE) ? ~phase_q : phase_q;
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) phase_q <= 1'b0;
    else phase_q <= phase_d;
  end
`else
  logic unused_breathe;
  assign unused_breathe = breathe;
  assign brth = 1'b0;
  assign phase_q = 1'b0;
`endif
  always_comb begin
    goal_r = phase_q ? 8'h00 : target_r;
    goal_g = phase_q ? 8'h00 : target_g;
    goal_b = phase_q ? 8'h00 : target_b;
    at_goal = (duty_r_q == goal_r) && (duty_g_q == goal_g) && (duty_b_q == goal_b);
    step = (step_size == '0) ? 9'd1 : 9'(step_size);
    clr = (state_q != RAMP) || !ena;
    upd = !clr && tick;
    duty_r_d = upd ? step_toward(duty_r_q, goal_r, step) : duty_r_q;
    duty_g_d = upd ? step_toward(duty_g_q, goal_g, step) : duty_g_q;
    duty_b_d = upd ? step_toward(duty_b_q, goal_b, step) : duty_b_q;
    state_d = !ena ? IDLE
            : (state_q == IDLE) ? (at_goal ? IDLE : RAMP)
            : (state_q == RAMP) ? (at_goal ? DONE : RAMP)
            : (brth ? RAMP : IDLE);
  end
  led_fade_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk(clk), .resetb(resetb), .clr(clr), .period(step_div), .tick(tick)
  );
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      duty_r_q <= 8'h00;
      duty_g_q <= 8'h00;
      duty_b_q <= 8'h00;
    end else begin
      state_q <= state_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
    end
  end
  assign duty_r = duty_r_q;
  assign duty_g = duty_g_q;
  assign duty_b = duty_b_q;
  assign busy = (state_q == RAMP);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_led_fade_ctrl.sv
// tb_led_fade_ctrl: directed steps with a duty-change scoreboard for led_fade_ctrl
module tb_led_fade_ctrl;
  logic clk, resetb, ena, breathe, busy, done;
  logic [7:0] target_r, target_g, target_b, duty_r, duty_g, duty_b;
  logic [15:0] step_div;
  logic [3:0] step_size;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;
  logic [23:0] exp_q[$];
  logic [23:0] prev = '0;
  logic [23:0] cur;
  led_fade_ctrl #(.DIV_W(16), .STEP_W(4)) dut (
    .clk(clk), .resetb(resetb), .ena(ena),
    .target_r(target_r), .target_g(target_g), .target_b(target_b),
    .step_div(step_div), .step_size(step_size), .breathe(breathe),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask
  always @(posedge clk) begin
    #3;
    if (!resetb) prev = '0;
    else begin
      if (done) done_cnt++;
      cur = {duty_r, duty_g, duty_b};
      if (cur !== prev) begin
        if (exp_q.size() == 0) chk("sb_unexpected", 32'(cur), 32'(prev));
        else chk("sb_seq", 32'(cur), 32'(exp_q.pop_front()));
        prev = cur;
      end
    end
  end
  initial begin
    resetb = 1'b0; ena = 1'b0; breathe = 1'b0;
    target_r = 8'h00; target_g = 8'h00; target_b = 8'h00;
    step_div = 16'd0; step_size = 4'd0;
    cyc(2);
    chk("rst_duty", 32'({duty_r, duty_g, duty_b}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    resetb = 1'b1;
    cyc(1);
    target_r = 8'h10; step_size = 4'd4; ena = 1'b1; d0 = done_cnt;
    for (int i = 1; i <= 4; i++) exp_q.push_back({8'(4 * i), 16'h0000});
    cyc(1);
    chk("r_entry_busy", 32'(busy), 32'd1);
    chk("r_entry_duty", 32'(duty_r), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("r_duty", 32'(duty_r), (k >= 4) ? 32'h10 : 32'(4 * k));
      chk("r_busy", 32'(busy), 32'(k <= 4));
      chk("r_done", 32'(done), 32'(k == 5));
    end
    chk("r_done_cnt", 32'(done_cnt - d0), 32'd1);
    target_g = 8'hFE; step_size = 4'd15;
    for (int i = 1; i <= 16; i++) exp_q.push_back({8'h10, 8'(15 * i), 8'h00});
    exp_q.push_back({8'h10, 8'hFE, 8'h00});
    wait_done("g_up_done");
    cyc(1);
    target_g = 8'h00;
    for (int i = 1; i <= 16; i++) exp_q.push_back({8'h10, 8'(254 - 15 * i), 8'h00});
    exp_q.push_back(24'h100000);
    wait_done("g_down_done");
    cyc(1);
    chk("g_floor", 32'(duty_g), 32'd0);
    chk("g_idle_busy", 32'(busy), 32'd0);
    step_div = 16'd3; target_b = 8'h02; step_size = 4'd1;
    exp_q.push_back(24'h100001);
    exp_q.push_back(24'h100002);
    for (int k = 0; k <= 10; k++) begin
      cyc(1);
      chk("b_div_duty", 32'(duty_b), (k >= 8) ? 32'd2 : (k >= 4) ? 32'd1 : 32'd0);
      chk("b_div_done", 32'(done), 32'(k == 9));
    end
    step_div = 16'd0; step_size = 4'd0; target_b = 8'h04;
    exp_q.push_back(24'h100003);
    exp_q.push_back(24'h100004);
    wait_done("step0_done");
    cyc(1);
    chk("step0_duty", 32'(duty_b), 32'd4);
    ena = 1'b0; resetb = 1'b0;
    cyc(1);
    resetb = 1'b1;
    target_b = 8'h00; step_size = 4'd4; ena = 1'b1;
    for (int i = 1; i <= 4; i++) exp_q.push_back({8'(4 * i), 16'h0000});
    cyc(3);
    chk("ena_mid_duty", 32'(duty_r), 32'h08);
    ena = 1'b0; d0 = done_cnt;
    for (int k = 3; k <= 5; k++) begin
      cyc(1);
      chk("ena_off_hold", 32'(duty_r), 32'h08);
      chk("ena_off_busy", 32'(busy), 32'd0);
      chk("ena_off_done", 32'(done), 32'd0);
    end
    ena = 1'b1;
    wait_done("ena_resume_done");
    chk("ena_resume_cnt", 32'(done_cnt - d0), 32'd1);
    chk("ena_resume_duty", 32'(duty_r), 32'h10);
    cyc(1);
    target_r = 8'h40;
    exp_q.push_back(24'h140000);
    exp_q.push_back(24'h180000);
    exp_q.push_back(24'h1C0000);
    cyc(4);
    chk("arst_pre_duty", 32'(duty_r), 32'h1C);
    #2 resetb = 1'b0;
    #1;
    chk("arst_duty", 32'({duty_r, duty_g, duty_b}), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    ena = 1'b0;
    cyc(2);
    resetb = 1'b1;
    cyc(2);
    chk("arst_stays_idle", 32'(busy), 32'd0);
`ifdef LED_FADE_BREATHE_EN
    target_r = 8'h08; step_size = 4'd8; breathe = 1'b1; ena = 1'b1; d0 = done_cnt;
    exp_q.push_back(24'h080000);
    exp_q.push_back(24'h000000);
    exp_q.push_back(24'h080000);
    exp_q.push_back(24'h000000);
    for (int k = 0; k <= 10; k++) begin
      cyc(1);
      chk("brth_active", 32'(busy | done), 32'd1);
    end
    chk("brth_done_cnt", 32'(done_cnt - d0), 32'd3);
    ena = 1'b0; breathe = 1'b0;
    cyc(2);
`endif
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
